fetch_unit_q: RTL and testbench
===============================

Name: fetch_unit_q

Overview:
Fully synchronous, parametrised instruction-fetch stage. It runs the fetch PC, issues single-outstanding requests to the ICache, and consults the branch predictor on each returned instruction. Fetched instructions are buffered in an IQ_DEPTH-entry instruction queue that feeds the decoder through a valid/ready handshake. It sits between the ICache and the decoder, and the ROB can redirect it.

Parameters:
ADDR_W, 32, fetch address width
INSTR_W, 32, instruction width
IQ_DEPTH, 4, instruction-queue entries; power of two, minimum 2
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset rst, synchronous, active-high
rdy  in  1  global ready; when low, all state holds
redirect_valid  in  1  ROB mispredict redirect, one-cycle pulse
redirect_pc  in  ADDR_W  correct PC from the ROB
icache_req  out  1  fetch request; held high until icache_valid
icache_addr  out  ADDR_W  request address; stable while icache_req is high
icache_valid  in  1  response strobe, one cycle
icache_instr  in  INSTR_W  response data
pred_pc  out  ADDR_W  PC of the returning instruction (equals icache_addr)
pred_instr  out  INSTR_W  equals icache_instr
pred_taken  in  1  combinational predictor result, same cycle
pred_target  in  ADDR_W  predicted target
dec_valid  out  1  queue head valid
dec_ready  in  1  decoder accepts the head
dec_instr  out  INSTR_W  head instruction
dec_pc  out  ADDR_W  head PC
dec_pred_taken  out  1  head prediction bit (forwarded to the ROB)
iq_count  out  $clog2(IQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset: pc=RESET_PC; icache_req=0; queue empty (dec_valid=0, iq_count=0); dec_instr/dec_pc=0; state=IDLE.
- rdy=0: no register changes, no push, no pop. Outputs hold their values.
- FSM states:
  - IDLE: if iq_count+push-pop < IQ_DEPTH, assert icache_req with icache_addr=pc in the next cycle and go to WAIT.
  - WAIT: hold the request. On icache_valid:
    - Push {icache_instr, pc, pred_taken}.
    - pc <= pred_taken ? pred_target : pc+4 (modulo 2^ADDR_W).
    - Return to IDLE. Back-to-back is allowed: if space remains, the request for the new pc is raised in the cycle after the response.
  - DROP: a stale request is outstanding. On icache_valid, discard the data (no push, no predictor use) and go to IDLE.
- Space gating: a request is raised only when a slot is guaranteed at response time. A push therefore never sees a full queue. Push and pop in the same cycle are legal at any occupancy.
- Decoder handshake: a pop occurs when dec_valid && dec_ready. Head outputs are driven from registered queue storage (read pointer), with zero added latency. Latency from icache_valid to dec_valid is 1 cycle.
- Redirect (highest priority, takes effect even with queue full or a pop pending):
  - Flush the queue (pointers and count to 0). dec_valid is forced to 0 in the redirect cycle, so any pop in that cycle is void.
  - pc <= redirect_pc.
  - From WAIT without icache_valid in the same cycle: go to DROP, keeping icache_req high until the response.
  - From WAIT with icache_valid in the same cycle: discard the response and go to IDLE.
  - From IDLE or DROP: go to IDLE or stay in DROP respectively.
  - The first request to redirect_pc is raised no earlier than the cycle after the redirect, and after the DROP completes.
- A redirect during a DROP overwrites pc; only the latest redirect is used.
- The predictor is consulted only in cycles where a response is actually pushed. pred_pc and pred_instr are don't-care at other times.
- The queue wraps its pointers modulo IQ_DEPTH; iq_count saturates logically at IQ_DEPTH.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_fetched (count of pushes), perf_redirects (count of redirect pulses) and perf_stall (count of cycles with the queue full and the FSM in IDLE). All are reset to 0 and wrap on overflow.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared define.v holds `TRUE, `FALSE, `NULL32, the ADDR and INSTRLEN width ranges, and FSM state encodings FQ_IDLE, FQ_WAIT, FQ_DROP (2 bits).
- One sub-module, fetch_iq: a synchronous circular FIFO parametrised on width and depth, with push, pop, flush, count, and head outputs.
- fetch_unit_q contains the FSM, PC logic and predictor glue.

Test Plan:
- Reset release, dec_ready=1, ICache latency 2 -> requests at 0x0, 0x4, 0x8. The first dec_valid comes 1 cycle after the first icache_valid, with dec_pc=0x0.
- pred_taken=1 with pred_target=0x100 on the response for 0x8 -> the next icache_addr is 0x100, and the entry for 0x8 has dec_pred_taken=1.
- IQ_DEPTH=4, dec_ready=0 -> exactly 4 pushes, iq_count=4, icache_req stays 0. Raising dec_ready for 1 cycle -> exactly one new request.
- redirect_valid to 0x200 while in WAIT, response 3 cycles later -> that response is dropped, the queue is empty, and the next icache_addr is 0x200.
- redirect_valid coincident with icache_valid and a pop, queue at 3 -> iq_count=0, no push, and the next request goes to redirect_pc.
- rdy=0 for 5 cycles mid-WAIT -> all outputs unchanged. Fetch resumes correctly when rdy returns to 1.

Source files
------------

// File: rtl/fetch_unit_q_pkg.sv
// Shared types and constants for the fetch unit: FSM state encoding, boolean and
// width defaults, and the PC step used for sequential fetch.
package fetch_unit_q_pkg;

   localparam logic        TRUE   = 1'b1;
   localparam logic        FALSE  = 1'b0;
   localparam logic [31:0] NULL32 = 32'h0;

   localparam int unsigned ADDR_W_DFLT  = 32;
   localparam int unsigned INSTR_W_DFLT = 32;
   localparam int unsigned PC_STEP      = 4;

   typedef enum logic [1:0] {
      FqIdle = 2'd0,
      FqWait = 2'd1,
      FqDrop = 2'd2
   } fq_state_e;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned iq_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_unit_q_iq.sv
// fetch_iq: synchronous circular FIFO with flush, occupancy count and a head read
// straight from registered storage (no added latency).
module fetch_iq
   import fetch_unit_q_pkg::*;
#(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [Width-1:0]         wdata_i,
   output logic [Width-1:0]         rdata_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = iq_cnt_w(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rptr_q, wptr_q;
   logic [CntW-1:0]  count_q;

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + PtrW'(1);
         end
         if (pop_i) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   always_comb begin
      rdata_o = mem_q[rptr_q];
      empty_o = (count_q == '0);
      count_o = count_q;
   end

endmodule

// File: rtl/fetch_unit_q.sv
// Instruction-fetch stage: fetch PC, single-outstanding ICache requests, predictor
// glue and an instruction queue. `FETCH_PERF_CNT_EN adds performance counters.
module fetch_unit_q
   import fetch_unit_q_pkg::*;
#(
   parameter int unsigned      ADDR_W   = ADDR_W_DFLT,
   parameter int unsigned      INSTR_W  = INSTR_W_DFLT,
   parameter int unsigned      IQ_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      redirect_valid,
   input  logic [ADDR_W-1:0]         redirect_pc,
   output logic                      icache_req,
   output logic [ADDR_W-1:0]         icache_addr,
   input  logic                      icache_valid,
   input  logic [INSTR_W-1:0]        icache_instr,
   output logic [ADDR_W-1:0]         pred_pc,
   output logic [INSTR_W-1:0]        pred_instr,
   input  logic                      pred_taken,
   input  logic [ADDR_W-1:0]         pred_target,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [INSTR_W-1:0]        dec_instr,
   output logic [ADDR_W-1:0]         dec_pc,
   output logic                      dec_pred_taken,
   output logic [$clog2(IQ_DEPTH):0] iq_count
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]               perf_fetched,
   output logic [31:0]               perf_redirects,
   output logic [31:0]               perf_stall
`endif
);

   localparam int unsigned CntW = iq_cnt_w(IQ_DEPTH);
   localparam int unsigned IqW  = INSTR_W + ADDR_W + 1;

   fq_state_e         state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic              req_q;

   logic              redir, pop, push, space, iq_empty;
   logic [CntW-1:0]   cnt_next;
   logic [ADDR_W-1:0] next_pc;
   logic [IqW-1:0]    iq_wdata, iq_rdata;

   always_comb begin
      redir     = rdy & redirect_valid;
      dec_valid = ~iq_empty & ~redir;
      pop       = rdy & dec_valid & dec_ready;
      push      = rdy & icache_valid & (state_q == FqWait) & ~redir;
      // Occupancy as it will be after this edge; a request is only raised if the
      // response is then guaranteed a slot.
      cnt_next  = iq_count + CntW'(push) - CntW'(pop);
      space     = (cnt_next < CntW'(IQ_DEPTH));
      next_pc   = pred_taken ? pred_target : pc_q + ADDR_W'(PC_STEP);
      iq_wdata  = {icache_instr, pc_q, pred_taken};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FqIdle;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= FALSE;
      end else if (rdy) begin
         if (redir) begin
            pc_q <= redirect_pc;
            unique case (state_q)
               FqWait: begin
                  if (icache_valid) begin
                     state_q <= FqIdle;
                     req_q   <= FALSE;
                  end else begin
                     state_q <= FqDrop;
                  end
               end
               FqDrop: begin
                  if (icache_valid) begin
                     state_q <= FqIdle;
                     req_q   <= FALSE;
                  end
               end
               default: state_q <= FqIdle;
            endcase
         end else begin
            unique case (state_q)
               FqIdle: begin
                  if (space) begin
                     state_q <= FqWait;
                     req_q   <= TRUE;
                     addr_q  <= pc_q;
                  end
               end
               FqWait: begin
                  if (icache_valid) begin
                     pc_q <= next_pc;
                     // Back-to-back: keep the request up and move to the new PC.
                     if (space) begin
                        addr_q <= next_pc;
                     end else begin
                        state_q <= FqIdle;
                        req_q   <= FALSE;
                     end
                  end
               end
               FqDrop: begin
                  if (icache_valid) begin
                     state_q <= FqIdle;
                     req_q   <= FALSE;
                  end
               end
               default: begin
                  state_q <= FqIdle;
                  req_q   <= FALSE;
               end
            endcase
         end
      end
   end

   fetch_iq #(
      .Width (IqW),
      .Depth (IQ_DEPTH)
   ) u_iq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redir),
      .wdata_i (iq_wdata),
      .rdata_o (iq_rdata),
      .empty_o (iq_empty),
      .count_o (iq_count)
   );

   always_comb begin
      icache_req                              = req_q;
      icache_addr                             = addr_q;
      pred_pc                                 = addr_q;
      pred_instr                              = icache_instr;
      {dec_instr, dec_pc, dec_pred_taken}     = iq_rdata;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_redirects_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q   <= NULL32;
         perf_redirects_q <= NULL32;
         perf_stall_q     <= NULL32;
      end else if (rdy) begin
         if (push)  perf_fetched_q   <= perf_fetched_q + 32'd1;
         if (redir) perf_redirects_q <= perf_redirects_q + 32'd1;
         if ((iq_count == CntW'(IQ_DEPTH)) && (state_q == FqIdle)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   always_comb begin
      perf_fetched   = perf_fetched_q;
      perf_redirects = perf_redirects_q;
      perf_stall     = perf_stall_q;
   end
`endif

endmodule

// File: tb/tb_fetch_unit_q.sv
// Self-checking bench for fetch_unit_q: ICache responder with random latency and a
// transaction-level model (expected PC stream plus a queue of fetched entries).
module tb_fetch_unit_q;

   localparam int unsigned AW = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst, rdy, redirect_valid, icache_valid, pred_taken, dec_ready;
   logic [AW-1:0] redirect_pc, pred_target, icache_addr, pred_pc, dec_pc;
   logic [IW-1:0] icache_instr, pred_instr, dec_instr;
   logic          icache_req, dec_valid, dec_pred_taken;
   logic [CW-1:0] iq_count;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   perf_fetched, perf_redirects, perf_stall;
`endif

   always #5 clk = ~clk;

   fetch_unit_q #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .IQ_DEPTH (D),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .icache_req     (icache_req),
      .icache_addr    (icache_addr),
      .icache_valid   (icache_valid),
      .icache_instr   (icache_instr),
      .pred_pc        (pred_pc),
      .pred_instr     (pred_instr),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_pred_taken (dec_pred_taken),
      .iq_count       (iq_count)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects),
      .perf_stall     (perf_stall)
`endif
   );

   typedef struct packed {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
      logic          taken;
   } ent_t;

   ent_t          mq[$];
   int            n_cmp = 0;
   int            n_err = 0;

   // Model state: next expected fetch PC and the outstanding ICache transaction.
   logic [AW-1:0] m_pc = '0;
   logic [AW-1:0] rec_addr = '0;
   bit            outst = 0;
   bit            stale = 0;
   int unsigned   lat = 0;
   int            n_req = 0;

   // Stimulus knobs.
   int unsigned   pct_rdy = 100, pct_redir = 0, pct_ready = 100, pct_taken = 0;
   int unsigned   lat_lo = 2, lat_hi = 2;
   bit            taken_at8 = 0;
   bit            force_redir = 0;
   logic [AW-1:0] force_pc = '0;

   bit            prev_hold = 0;
   logic          s_req, s_dv;
   logic [AW-1:0] s_addr, s_pc;
   logic [IW-1:0] s_instr;
   logic [CW-1:0] s_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      logic redir, exp_dv;
      ent_t e;
      @(negedge clk);
      if (outst) begin
         check_eq("req_held", 64'(icache_req), 64'(1));
         check_eq("addr_stable", 64'(icache_addr), 64'(rec_addr));
      end else if (icache_req) begin
         check_eq("req_addr", 64'(icache_addr), 64'(m_pc));
         rec_addr = m_pc;
         outst    = 1;
         stale    = 0;
         lat      = $urandom_range(lat_hi, lat_lo);
         n_req++;
      end

      rdy            = ($urandom_range(99) < pct_rdy);
      dec_ready      = ($urandom_range(99) < pct_ready);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      icache_valid   = 1'b0;
      icache_instr   = $urandom;
      pred_taken     = 1'b0;
      pred_target    = $urandom & 32'hFFFF_FFFC;
      if (rdy) begin
         if (outst && lat == 0) icache_valid = 1'b1;
         else if (outst) lat--;
         if (icache_valid) begin
            pred_taken = ($urandom_range(99) < pct_taken);
            if (taken_at8 && rec_addr == 32'h8) begin
               pred_taken  = 1'b1;
               pred_target = 32'h100;
            end
         end
         if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 0;
         end else if ($urandom_range(99) < pct_redir) begin
            redirect_valid = 1'b1;
         end
      end
      #1;

      redir  = rdy && redirect_valid;
      exp_dv = (mq.size() != 0) && !redir;
      check_eq("dec_valid", 64'(dec_valid), 64'(exp_dv));
      check_eq("iq_count", 64'(iq_count), 64'(mq.size()));
      if (exp_dv) begin
         check_eq("dec_pc", 64'(dec_pc), 64'(mq[0].pc));
         check_eq("dec_instr", 64'(dec_instr), 64'(mq[0].instr));
         check_eq("dec_taken", 64'(dec_pred_taken), 64'(mq[0].taken));
      end
      if (prev_hold) begin
         check_eq("hold_req", 64'(icache_req), 64'(s_req));
         check_eq("hold_addr", 64'(icache_addr), 64'(s_addr));
         check_eq("hold_cnt", 64'(iq_count), 64'(s_cnt));
         check_eq("hold_pc", 64'(dec_pc), 64'(s_pc));
         check_eq("hold_instr", 64'(dec_instr), 64'(s_instr));
         if (!redir) check_eq("hold_dv", 64'(dec_valid), 64'(s_dv));
      end
      s_req = icache_req; s_addr = icache_addr; s_cnt = iq_count;
      s_pc = dec_pc; s_instr = dec_instr; s_dv = dec_valid;
      prev_hold = !rdy;

      if (rdy) begin
         if (redir) begin
            mq.delete();
            m_pc = redirect_pc;
            if (outst) begin
               if (icache_valid) outst = 0;
               else stale = 1;
            end
         end else begin
            if (exp_dv && dec_ready) void'(mq.pop_front());
            if (icache_valid) begin
               if (!stale) begin
                  check_eq("push_space", 64'(mq.size() < int'(D)), 64'(1));
                  e.instr = icache_instr;
                  e.pc    = rec_addr;
                  e.taken = pred_taken;
                  mq.push_back(e);
                  m_pc = pred_taken ? pred_target : rec_addr + 32'd4;
               end
               outst = 0;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      icache_valid = 1'b0; icache_instr = '0; pred_taken = 1'b0; pred_target = '0;
      dec_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req", 64'(icache_req), 64'(0));
      check_eq("rst_dv", 64'(dec_valid), 64'(0));
      check_eq("rst_cnt", 64'(iq_count), 64'(0));
      check_eq("rst_pc", 64'(dec_pc), 64'(0));
      check_eq("rst_instr", 64'(dec_instr), 64'(0));
      rst = 1'b0;

      // Sequential fetch from reset, with a taken prediction on 0x8 -> 0x100.
      taken_at8 = 1;
      repeat (24) step();
      taken_at8 = 0;

      // Decoder stalled: queue fills to exactly D and fetch stops.
      pct_ready = 0;
      repeat (30) step();
      check_eq("full_cnt", 64'(iq_count), 64'(D));
      check_eq("full_noreq", 64'(icache_req), 64'(0));
      n_req = 0;
      pct_ready = 100;
      step();
      pct_ready = 0;
      repeat (15) step();
      check_eq("one_req", 64'(n_req), 64'(1));
      check_eq("refull_cnt", 64'(iq_count), 64'(D));

      // Redirect while a request is outstanding: response dropped, refetch at 0x200.
      pct_ready = 100; lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 50 && !(outst && lat > 1); i++) step();
      check_eq("reach_wait", 64'(outst), 64'(1));
      force_redir = 1; force_pc = 32'h200;
      step();
      step();
      check_eq("redir_flush", 64'(iq_count), 64'(0));
      repeat (12) step();

      // Redirect coincident with a response and a pop at occupancy 3.
      pct_ready = 0; lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 100 && !(mq.size() == 3 && outst && lat == 0); i++) step();
      check_eq("reach_q3", 64'(mq.size() == 3 && outst && lat == 0), 64'(1));
      force_redir = 1; force_pc = 32'h300; pct_ready = 100;
      step();
      pct_ready = 0;
      step();
      check_eq("coinc_flush", 64'(iq_count), 64'(0));
      repeat (10) step();

      // rdy low for 5 cycles while waiting on the ICache.
      pct_ready = 100; lat_lo = 2; lat_hi = 4;
      for (int i = 0; i < 50 && !outst; i++) step();
      check_eq("reach_hold", 64'(outst), 64'(1));
      pct_rdy = 0;
      repeat (5) step();
      pct_rdy = 100;
      repeat (20) step();

      // Randomised traffic.
      pct_rdy = 90; pct_redir = 4; pct_ready = 60; pct_taken = 30; lat_lo = 0; lat_hi = 4;
      repeat (4000) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
